// File: rtl/serial_mag_compare.sv
// serial_mag_compare: folds MSB-first 1-bit comparator results into a registered magnitude verdict
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bit_valid,
    input  logic       bit_eq,
    input  logic       bit_lt,
    input  logic       bit_gt,
    output logic       busy,
    output logic       done,
    output logic       a_eq_b,
    output logic       a_lt_b,
    output logic       a_gt_b,
    output logic [7:0] bit_count,
    output logic       error
);
    typedef enum logic [1:0] {IDLE, SCAN, DECIDED, DONE} state_t;
    localparam logic [7:0] LAST = 8'(WIDTH - 1);
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic rel_lt_q, rel_lt_d, rel_gt_q, rel_gt_d, err_q, err_d;
    logic res_eq_q, res_eq_d, res_lt_q, res_lt_d, res_gt_q, res_gt_d;
    logic active, onehot, fin, latch;
    always_comb begin
        active = (state_q == SCAN || state_q == DECIDED) && bit_valid && !start;
        onehot = {bit_eq, bit_lt, bit_gt} inside {3'b100, 3'b010, 3'b001};
        fin    = active && cnt_q == LAST;
        latch  = active && state_q == SCAN && onehot;
    end
    always_comb begin
        state_d = start ? SCAN :
                  (state_q == IDLE || state_q == DONE) ? IDLE :
                  fin ? DONE :
                  (latch && !bit_eq) ? DECIDED : state_q;
    end
    always_comb begin
        cnt_d    = start ? 8'd0 : active ? cnt_q + 8'd1 : cnt_q;
        err_d    = !start && (err_q || (active && !onehot));
        rel_lt_d = start ? 1'b0 : latch ? bit_lt : rel_lt_q;
        rel_gt_d = start ? 1'b0 : latch ? bit_gt : rel_gt_q;
        res_eq_d = start ? 1'b0 : fin ? (!err_d && !rel_lt_d && !rel_gt_d) : res_eq_q;
        res_lt_d = start ? 1'b0 : fin ? (!err_d && rel_lt_d) : res_lt_q;
        res_gt_d = start ? 1'b0 : fin ? (!err_d && rel_gt_d) : res_gt_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            rel_lt_q <= 1'b0;
            rel_gt_q <= 1'b0;
            res_eq_q <= 1'b0;
            res_lt_q <= 1'b0;
            res_gt_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rel_lt_q <= rel_lt_d;
            rel_gt_q <= rel_gt_d;
            res_eq_q <= res_eq_d;
            res_lt_q <= res_lt_d;
            res_gt_q <= res_gt_d;
        end
    end
    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        a_eq_b    = res_eq_q;
        a_lt_b    = res_lt_q;
        a_gt_b    = res_gt_q;
        bit_count = cnt_q;
        error     = err_q;
    end
endmodule

// File: tb/tb_serial_mag_compare.sv
// tb_serial_mag_compare: random and directed checks of serial_mag_compare against a sequence-level model
module tb_serial_mag_compare;
    localparam logic [2:0] EQ = 3'b100, LT = 3'b010, GT = 3'b001;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0;
    logic bit_valid = 1'b0, bit_eq = 1'b0, bit_lt = 1'b0, bit_gt = 1'b0;
    logic busy4, done4, eq4, lt4, gt4, err4, busy1, done1, eq1, lt1, gt1, err1;
    logic [7:0] cnt4, cnt1;
    logic [2:0] seq [4];
    int n_chk = 0, n_err = 0, n_done4 = 0, d0;

    serial_mag_compare #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .bit_eq(bit_eq), .bit_lt(bit_lt), .bit_gt(bit_gt),
        .busy(busy4), .done(done4), .a_eq_b(eq4), .a_lt_b(lt4), .a_gt_b(gt4),
        .bit_count(cnt4), .error(err4)
    );
    serial_mag_compare #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bit_valid(bit_valid),
        .bit_eq(bit_eq), .bit_lt(bit_lt), .bit_gt(bit_gt),
        .busy(busy1), .done(done1), .a_eq_b(eq1), .a_lt_b(lt1), .a_gt_b(gt1),
        .bit_count(cnt1), .error(err1)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done4) n_done4 <= n_done4 + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {error, eq, lt, gt}: any non-one-hot pair poisons the result, else the first differing pair decides
    function automatic logic [3:0] model();
        logic err = 1'b0;
        int rel = 0;
        for (int i = 0; i < 4; i++) begin
            if ($countones(seq[i]) != 1) err = 1'b1;
            else if (rel == 0 && seq[i] != EQ) rel = (seq[i] == LT) ? 1 : 2;
        end
        return err ? 4'b1000 : {1'b0, rel == 0, rel == 1, rel == 2};
    endfunction

    task automatic do_start();
        start = 1'b1;
        bit_valid = 1'b1;
        {bit_eq, bit_lt, bit_gt} = GT;
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [2:0] f, input int gap);
        repeat (gap) begin
            bit_valid = 1'b0;
            {bit_eq, bit_lt, bit_gt} = 3'($urandom);
            @(negedge clk);
        end
        bit_valid = 1'b1;
        {bit_eq, bit_lt, bit_gt} = f;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic run4(input string tag, input int gap);
        logic [3:0] exp;
        int s = n_done4;
        exp = model();
        do_start();
        check({tag, " start"}, {busy4, done4, cnt4, err4, eq4, lt4, gt4}, {2'b10, 8'd0, 4'b0000});
        for (int i = 0; i < 4; i++) begin
            send_pair(seq[i], gap < 0 ? int'($urandom_range(0, 2)) : gap);
            if (i < 3) check({tag, " count"}, {done4, cnt4}, {1'b0, 8'(i + 1)});
        end
        check({tag, " done"}, {busy4, done4, cnt4}, {2'b11, 8'd4});
        check({tag, " verdict"}, {err4, eq4, lt4, gt4}, exp);
        @(negedge clk);
        check({tag, " after"}, {busy4, done4, err4, eq4, lt4, gt4}, {2'b00, exp});
        check({tag, " pulses"}, n_done4 - s, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset", {busy4, done4, cnt4, err4, eq4, lt4, gt4}, 13'd0);
        rst_n = 1'b1;
        repeat (2) send_pair(GT, 0);
        check("idle ignore", {busy4, cnt4}, 9'd0);

        seq = '{EQ, EQ, GT, LT};
        run4("gt", 0);
        seq = '{EQ, EQ, EQ, EQ};
        run4("eq gaps", 2);
        seq = '{LT, GT, GT, EQ};
        run4("first wins", 0);
        seq = '{EQ, 3'b101, GT, EQ};
        run4("illegal", 1);

        d0 = n_done4;
        do_start();
        send_pair(LT, 0);
        send_pair(EQ, 1);
        seq = '{EQ, EQ, EQ, EQ};
        run4("abort", 0);
        check("abort pulses", n_done4 - d0, 1);

        d0 = n_done4;
        do_start();
        send_pair(EQ, 0);
        send_pair(3'b110, 0);
        send_pair(LT, 0);
        check("sticky err", {err4, cnt4}, {1'b1, 8'd3});
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset", {busy4, done4, cnt4, err4, eq4, lt4, gt4}, 13'd0);
        rst_n = 1'b1;
        repeat (3) send_pair(EQ, 0);
        check("post reset", {busy4, cnt4}, 9'd0);
        check("reset pulses", n_done4 - d0, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                int r = int'($urandom_range(0, 9));
                seq[i] = (r == 0) ? 3'($urandom_range(0, 7)) : (r < 6) ? EQ : (r < 8) ? LT : GT;
            end
            repeat ($urandom_range(0, 2)) send_pair(3'($urandom), 0);
            run4("random", -1);
        end

        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        send_pair(GT, 0);
        check("w1 done", {busy1, done1, cnt1}, {2'b11, 8'd1});
        check("w1 verdict", {err1, eq1, lt1, gt1}, 4'b0001);
        @(negedge clk);
        check("w1 after", {busy1, done1, gt1}, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
